branch_predictor_bht: RTL and testbench

- 2-bit saturating-counter branch history table (BHT), upstream of the ID-stage hazard detection logic.
- Indexed from the IF-stage PC. The prediction is registered into the IF/ID boundary so it is ID-aligned; the hazard logic compares it with the resolved `branch_taken`.
- Counters are trained from the EX-stage resolution port.
- The table index travels down the pipe with the instruction and returns on update, so training always hits the entry that produced the prediction.

---
 rtl/branch_predictor_bht.sv | 50 +++++
 tb/tb_branch_predictor_bht.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: 2-bit saturating-counter BHT with an IF/ID-registered prediction.
// Define BHT_GSHARE_EN to XOR a non-speculative global history register into the lookup index.
module branch_predictor_bht #(
  parameter int INDEX_W = 6,
  parameter int XLEN = 32,
  parameter logic [1:0] CTR_RESET = 2'b01
) (
  input  logic clk,
  input  logic rst,
  input  logic [XLEN-1:0] pc_if,
  input  logic if_id_write,
  input  logic flush,
  output logic pred_taken_id,
  output logic [INDEX_W-1:0] pred_idx_id,
  input  logic upd_valid,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic upd_taken
);
  logic [1:0] ctr [2**INDEX_W];
  logic [INDEX_W-1:0] idx_if;
  logic pred_if;
  logic unused_pc;
  assign unused_pc = ^{pc_if[XLEN-1:INDEX_W+2], pc_if[1:0]};
`ifdef BHT_GSHARE_EN
  logic [INDEX_W-1:0] ghr;
  always_ff @(posedge clk or posedge rst)
    if (rst) ghr <= '0;
    else if (upd_valid) ghr <= {ghr[INDEX_W-2:0], upd_taken};
  assign idx_if = pc_if[INDEX_W+1:2] ^ ghr;
`else
  assign idx_if = pc_if[INDEX_W+1:2];
`endif
  assign pred_if = ctr[idx_if][1];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 2**INDEX_W; i++) ctr[i] <= CTR_RESET;
    else if (upd_valid)
      ctr[upd_idx] <= upd_taken ? (ctr[upd_idx] == 2'b11 ? 2'b11 : ctr[upd_idx] + 2'd1)
                                : (ctr[upd_idx] == 2'b00 ? 2'b00 : ctr[upd_idx] - 2'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pred_taken_id <= 1'b0;
      pred_idx_id <= '0;
    end else if (flush) begin
      pred_taken_id <= 1'b0;
      pred_idx_id <= '0;
    end else if (if_id_write) begin
      pred_taken_id <= pred_if;
      pred_idx_id <= idx_if;
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: randomized bench with an arithmetic reference model checked every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_branch_predictor_bht;
  localparam int IW = 6;
  localparam int N = 64;
  logic clk = 0, rst = 1;
  logic [31:0] pc_if = 0;
  logic if_id_write = 0, flush = 0, upd_valid = 0, upd_taken = 0;
  logic [IW-1:0] upd_idx = 0;
  logic pred_taken_id;
  logic [IW-1:0] pred_idx_id;
  int ctr_m [N];
  int ghr_m, pm, im;
  int passed = 0, total = 0;
  bit chk_en = 0;

  branch_predictor_bht #(.INDEX_W(IW), .XLEN(32), .CTR_RESET(2'b01)) dut (
    .clk(clk), .rst(rst), .pc_if(pc_if), .if_id_write(if_id_write), .flush(flush),
    .pred_taken_id(pred_taken_id), .pred_idx_id(pred_idx_id),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken));

  always #5 clk = ~clk;

  function automatic void check(string n, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, got, exp);
  endfunction

  always @(negedge clk)
    if (chk_en) begin
      check("model pred_taken_id", int'(pred_taken_id), pm);
      check("model pred_idx_id", int'(pred_idx_id), im);
    end

  function automatic void model_reset();
    for (int i = 0; i < N; i++) ctr_m[i] = 1;
    ghr_m = 0; pm = 0; im = 0;
  endfunction

  function automatic int lookup_idx(logic [31:0] pc);
`ifdef BHT_GSHARE_EN
    return ((pc / 4) % N) ^ ghr_m;
`else
    return (pc / 4) % N;
`endif
  endfunction

  task automatic step(input logic [31:0] pc, input logic w, input logic f,
                      input logic uv, input int ui, input logic ut);
    int idx, pr;
    pc_if = pc; if_id_write = w; flush = f; upd_valid = uv; upd_idx = IW'(ui); upd_taken = ut;
    @(posedge clk);
    idx = lookup_idx(pc);
    pr = ctr_m[idx] >= 2;
    if (f) begin pm = 0; im = 0; end
    else if (w) begin pm = pr; im = idx; end
    if (uv) begin
      ctr_m[ui] = ut ? (ctr_m[ui] + 1 > 3 ? 3 : ctr_m[ui] + 1) : (ctr_m[ui] - 1 < 0 ? 0 : ctr_m[ui] - 1);
      ghr_m = ((ghr_m * 2) + int'(ut)) % N;
    end
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(pc, 1, 0, 0, 0, 0);
  endtask

  task automatic upd(input int ui, input logic ut);
    step(32'h100, 0, 0, 1, ui, ut);
  endtask

  task automatic do_reset();
    if_id_write = 0; flush = 0; upd_valid = 0;
    rst = 1;
    model_reset();
    #1;
    check("async reset pred", int'(pred_taken_id), 0);
    check("async reset idx", int'(pred_idx_id), 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    model_reset();
    #2;
    @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;
`ifndef BHT_GSHARE_EN
    upd(5, 1); upd(5, 1);
    fetch(32'h14);
    check("trained idx5 pred", int'(pred_taken_id), 1);
    do_reset();
    fetch(32'h14);
    check("post-reset idx5 pred", int'(pred_taken_id), 0);
    check("post-reset idx5 idx", int'(pred_idx_id), 5);
    for (int i = 0; i < 4; i++) upd(3, 1);
    fetch(32'h0C);
    check("sat up pred", int'(pred_taken_id), 1);
    upd(3, 0);
    fetch(32'h0C);
    check("sat up one NT", int'(pred_taken_id), 1);
    upd(3, 0);
    fetch(32'h0C);
    check("sat up two NT", int'(pred_taken_id), 0);
    for (int i = 0; i < 3; i++) upd(7, 0);
    upd(7, 1);
    fetch(32'h1C);
    check("sat down no wrap", int'(pred_taken_id), 0);
    upd(7, 1);
    fetch(32'h1C);
    check("sat down then 2 T", int'(pred_taken_id), 1);
    upd(10, 1);
    fetch(32'h28);
    check("stall setup pred", int'(pred_taken_id), 1);
    for (int i = 0; i < 3; i++) begin
      step(32'h0C + 32'(4 * i), 0, 0, 0, 0, 0);
      check("stall hold pred", int'(pred_taken_id), 1);
      check("stall hold idx", int'(pred_idx_id), 10);
    end
    step(32'h28, 0, 1, 0, 0, 0);
    check("flush pred", int'(pred_taken_id), 0);
    check("flush idx", int'(pred_idx_id), 0);
    step(32'h24, 1, 0, 1, 9, 1);
    check("collision old value", int'(pred_taken_id), 0);
    check("collision idx", int'(pred_idx_id), 9);
    fetch(32'h24);
    check("collision new value", int'(pred_taken_id), 1);
`else
    do_reset();
    upd(0, 1); upd(0, 1);
    fetch(32'h0);
    check("gshare idx", int'(pred_idx_id), 3);
`endif
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(32'($urandom_range(0, 511)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
